// File: rtl/la_oser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// la_oser : multi-lane SDR/DDR output serializer with valid/ready input,
//           idle level and first-beat frame marker.
// Rev 1.0
// ---------------------------------------------------------------------------
module la_oser #(
  parameter     PROP     = "DEFAULT",
  parameter int LANES    = 1,
  parameter int RATIO    = 8,
  parameter int DDR      = 1,
  parameter int LSBFIRST = 1,
  parameter int IDLE     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*RATIO-1:0] in_data,
  output logic [LANES-1:0]       out,
  output logic                   busy,
  output logic                   frame
);

  localparam int             C_BEATS    = (DDR != 0) ? RATIO / 2 : RATIO;
  localparam int             C_CW       = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam int             C_STEP     = (DDR != 0) ? 2 : 1;
  localparam logic [C_CW-1:0] C_LAST    = C_CW'(C_BEATS - 1);
  localparam logic           C_IDLE_BIT = (IDLE != 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]             r_state;
  logic [C_CW-1:0]        r_count;
  logic                   r_frame;
  logic [LANES-1:0]       r_d_hi;
  logic [LANES-1:0]       r_d_lo;
  logic [LANES*RATIO-1:0] r_sr;
  logic [LANES*RATIO-1:0] w_stream;
  logic                   w_accept;

  // PROP only selects a technology mapping; it has no behavioural effect.
  if (PROP == "") begin : g_prop_none
  end

  // Reorder each lane slice into transmit order: stream bit 0 leaves first.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar p = 0; p < RATIO; p++) begin : g_bit
      assign w_stream[l*RATIO+p] = in_data[l*RATIO + ((LSBFIRST != 0) ? p : RATIO-1-p)];
    end
  end

  assign in_ready = ~reset & ((r_state == ST_IDLE) |
                              ((r_state == ST_SHIFT) & (r_count == C_LAST)));
  assign w_accept = in_valid & in_ready;
  assign busy     = (r_state == ST_SHIFT);
  assign frame    = r_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_frame <= 1'b0;
      r_d_hi  <= {LANES{C_IDLE_BIT}};
      r_d_lo  <= {LANES{C_IDLE_BIT}};
      r_sr    <= '0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_count <= '0;
      r_frame <= 1'b1;
      for (int l = 0; l < LANES; l++) begin
        r_d_hi[l] <= w_stream[l*RATIO];
        r_d_lo[l] <= (DDR != 0) ? w_stream[l*RATIO+1] : C_IDLE_BIT;
        r_sr[l*RATIO +: RATIO] <= w_stream[l*RATIO +: RATIO] >> C_STEP;
      end
    end else begin
      r_frame <= 1'b0;
      if (r_state == ST_SHIFT) begin
        if (r_count == C_LAST) begin
          r_state <= ST_IDLE;
          r_d_hi  <= {LANES{C_IDLE_BIT}};
          r_d_lo  <= {LANES{C_IDLE_BIT}};
        end else begin
          r_count <= r_count + 1'b1;
          for (int l = 0; l < LANES; l++) begin
            r_d_hi[l] <= r_sr[l*RATIO];
            r_d_lo[l] <= (DDR != 0) ? r_sr[l*RATIO+1] : C_IDLE_BIT;
            r_sr[l*RATIO +: RATIO] <= r_sr[l*RATIO +: RATIO] >> C_STEP;
          end
        end
      end
    end
  end

  // Both DDR registers settle at posedge, so d_lo is stable through the low phase.
  assign out = ((DDR == 0) || clk) ? r_d_hi : r_d_lo;

endmodule
`default_nettype wire

// File: tb/tb_la_oser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_la_oser : four la_oser configurations against a per-word bit-stream model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_la_oser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  val;
  logic [17:0] dat [4];
  logic [3:0]  rdy, bsy, frm;
  logic [0:0]  o0;
  logic [1:0]  o1;
  logic [0:0]  o2;
  logic [2:0]  o3;

  int n_cmp = 0;
  int n_err = 0;

  la_oser #(.LANES(1), .RATIO(8), .DDR(0), .LSBFIRST(1), .IDLE(0)) u_i0 (
    .clk(clk), .reset(rst), .in_valid(val[0]), .in_ready(rdy[0]),
    .in_data(dat[0][7:0]), .out(o0), .busy(bsy[0]), .frame(frm[0]));
  la_oser #(.LANES(2), .RATIO(4), .DDR(1), .LSBFIRST(1), .IDLE(0)) u_i1 (
    .clk(clk), .reset(rst), .in_valid(val[1]), .in_ready(rdy[1]),
    .in_data(dat[1][7:0]), .out(o1), .busy(bsy[1]), .frame(frm[1]));
  la_oser #(.LANES(1), .RATIO(8), .DDR(0), .LSBFIRST(0), .IDLE(1)) u_i2 (
    .clk(clk), .reset(rst), .in_valid(val[2]), .in_ready(rdy[2]),
    .in_data(dat[2][7:0]), .out(o2), .busy(bsy[2]), .frame(frm[2]));
  la_oser #(.LANES(3), .RATIO(6), .DDR(1), .LSBFIRST(0), .IDLE(1)) u_i3 (
    .clk(clk), .reset(rst), .in_valid(val[3]), .in_ready(rdy[3]),
    .in_data(dat[3][17:0]), .out(o3), .busy(bsy[3]), .frame(frm[3]));

  function automatic int c_lanes(int i);
    case (i) 0: return 1; 1: return 2; 2: return 1; default: return 3; endcase
  endfunction
  function automatic int c_ratio(int i);
    case (i) 0: return 8; 1: return 4; 2: return 8; default: return 6; endcase
  endfunction
  function automatic int c_ddr(int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction
  function automatic int c_lsb(int i);
    return (i <= 1) ? 1 : 0;
  endfunction
  function automatic logic c_idle(int i);
    return (i >= 2);
  endfunction
  function automatic int c_beats(int i);
    return (c_ddr(i) != 0) ? c_ratio(i) / 2 : c_ratio(i);
  endfunction

  function automatic logic [2:0] get_out(int i);
    case (i)
      0: return {2'b00, o0};
      1: return {1'b0, o1};
      2: return {2'b00, o2};
      default: return o3;
    endcase
  endfunction

  // Model: the word in flight and which beat of it is on the pins.
  logic [17:0] m_word [4];
  int          m_beat [4];
  bit          m_act  [4];
  bit          m_acc  [4];

  function automatic logic exp_ready(int i);
    return !rst && (!m_act[i] || m_beat[i] == c_beats(i) - 1);
  endfunction

  // Stream position p of lane l, in transmit order.
  function automatic logic exp_bit(int i, int l, int p);
    int idx;
    if (!m_act[i]) return c_idle(i);
    idx = (c_lsb(i) != 0) ? p : c_ratio(i) - 1 - p;
    return m_word[i][l*c_ratio(i) + idx];
  endfunction

  function automatic logic [2:0] exp_out(int i, int lo);
    logic [2:0] e = 3'b000;
    for (int l = 0; l < c_lanes(i); l++)
      e[l] = exp_bit(i, l, (c_ddr(i) != 0) ? 2*m_beat[i] + lo : m_beat[i]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 4; i++) begin
      logic er;
      er       = exp_ready(i);
      m_acc[i] = 1'b0;
      if (rst) begin
        m_act[i]  = 1'b0;
        m_beat[i] = 0;
      end else if (val[i] && er) begin
        m_act[i]  = 1'b1;
        m_beat[i] = 0;
        m_word[i] = dat[i];
        m_acc[i]  = 1'b1;
      end else if (m_act[i]) begin
        if (m_beat[i] == c_beats(i) - 1) m_act[i] = 1'b0;
        else m_beat[i]++;
      end
    end
  endtask

  task automatic check_outs(input int lo);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out%s[%0d]", lo ? "_lo" : "_hi", i), 32'(get_out(i)), 32'(exp_out(i, lo)));
      if (lo == 0) begin
        check($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_act[i]));
        check($sformatf("frame[%0d]", i), 32'(frm[i]), 32'(m_act[i] && m_beat[i] == 0));
      end
    end
  endtask

  // Inputs for the coming edge are already applied when this is called.
  task automatic step();
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(exp_ready(i)));
    @(posedge clk);
    model_update();
    #2 check_outs(0);
    @(negedge clk);
    #2 check_outs(1);
  endtask

  int k;
  int n_acc;

  initial begin
    rst = 1'b1;
    val = '0;
    for (int i = 0; i < 4; i++) begin
      dat[i] = '0; m_word[i] = '0; m_beat[i] = 0; m_act[i] = 1'b0; m_acc[i] = 1'b0;
    end
    repeat (2) step();
    rst = 1'b0;
    step();

    // Single SDR word, LSB first.
    val[0] = 1'b1; dat[0] = 18'hA5; step();
    val[0] = 1'b0; repeat (9) step();

    // Single DDR word on two lanes.
    val[1] = 1'b1; dat[1] = 18'h6C; step();
    val[1] = 1'b0; repeat (3) step();

    // Back-to-back streaming, data advanced only after each acceptance.
    k = 1; val[0] = 1'b1; dat[0] = 18'h01;
    for (int g = 0; g < 40 && k <= 3; g++) begin
      step();
      if (m_acc[0]) begin
        k++;
        if (k <= 3) dat[0] = 18'(k);
        else val[0] = 1'b0;
      end
    end
    check("stream_words", 32'(k), 32'd4);
    repeat (9) step();

    // MSB first with idle-high lanes.
    val[2] = 1'b1; dat[2] = 18'h80; step();
    val[2] = 1'b0; repeat (10) step();

    // Backpressure: offer a word during beat 2 and hold it until taken.
    val[0] = 1'b1; dat[0] = 18'h3C; step();
    val[0] = 1'b0; step();
    val[0] = 1'b1; dat[0] = 18'hC3; n_acc = 0;
    for (int g = 0; g < 20 && n_acc == 0; g++) begin
      step();
      if (m_acc[0]) n_acc++;
    end
    val[0] = 1'b0;
    check("held_accepts", 32'(n_acc), 32'd1);
    repeat (9) step();

    // Reset in the middle of a word.
    val[0] = 1'b1; val[3] = 1'b1; dat[0] = 18'hFF; dat[3] = 18'h2D5A7; step();
    val[0] = 1'b0; val[3] = 1'b0; repeat (3) step();
    rst = 1'b1; val[0] = 1'b1; dat[0] = 18'h55; repeat (2) step();
    rst = 1'b0; val[0] = 1'b0; repeat (10) step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!val[i] || m_acc[i]) begin
          val[i] = ($urandom_range(0, 2) != 0);
          dat[i] = 18'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          val[i] = 1'b0;
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/la_oser.md
Name: la_oser

Overview:
- Parametrised output serializer; the multi-lane, multi-ratio successor of the single-bit DDR output buffer.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out on LANES pins at SDR or DDR rate, using the clock as the DDR phase selector.
- Sits between core-clock logic and pad drivers. Provides seamless back-to-back streaming, an idle level and a frame marker.

Parameters:
- PROP, "DEFAULT": technology/implementation property string, passed through.
- LANES, 1: number of serial output lanes.
- RATIO, 8: bits serialized per lane per word. Must be >=2; must be even when DDR=1.
- DDR, 1: 1 = two bits per lane per clk cycle; 0 = one bit per cycle.
- LSBFIRST, 1: 1 = bit 0 of each lane slice goes out first; 0 = bit RATIO-1 goes out first.
- IDLE, 0: level driven on all lanes (both phases) when no word is active.

Ports:
- clk, input, 1: clock; also the DDR phase selector.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data holds a word.
- in_ready, output, 1: block accepts a word this cycle.
- in_data, input, LANES*RATIO: lane l uses bits [l*RATIO +: RATIO].
- out, output, LANES: serial data per lane.
- busy, output, 1: a word is being shifted out.
- frame, output, 1: high during the first beat of each word.

Behaviour:
- BEATS = DDR ? RATIO/2 : RATIO. beat counter width = clog2(BEATS), minimum 1.
- Two states:
  - IDLE: in_ready=1, busy=0, lane registers hold IDLE.
  - SHIFT: busy=1, counter counts 0..BEATS-1.
- Accept occurs when in_valid & in_ready at a posedge:
  - Load the shift register.
  - Counter <= 0, state <= SHIFT.
  - Beat 0 is visible from that posedge; latency from accept edge to first bit is 0 cycles, i.e. bits appear in the cycle after the accepting cycle.
- in_ready = (state==IDLE) | (state==SHIFT & counter==BEATS-1). This is combinational from state, never from in_valid.
- Last beat with a new accept: reload, counter <= 0, state stays SHIFT. No idle gap between words.
- Last beat without an accept: state <= IDLE; lane registers <= IDLE at that edge.
- SDR: per lane, one register d_hi; out = d_hi for the whole cycle. Bit order per LSBFIRST.
- DDR: per lane, registers d_hi and d_lo, both updated at posedge.
  - out = clk ? d_hi : d_lo.
  - Within a beat, the earlier bit is driven in the clk-high phase and the later bit in the clk-low phase.
  - Beat k carries bits 2k and 2k+1 in stream order.
  - d_lo must not change while clk is low.
- frame = 1 for exactly the cycle containing beat 0 of each word, including back-to-back words. Otherwise 0.
- in_data is sampled only at the accepting edge; later changes have no effect.
- in_valid while not ready is ignored. The block does not require in_data to be held.
- Reset, sampled at posedge:
  - state IDLE; counter 0; d_hi = d_lo = IDLE; busy 0; frame 0.
  - in_ready is forced 0 while reset is high.
- Reset mid-word aborts the word; no remaining bits are emitted.
- in_valid concurrent with reset is dropped.

Test Plan:
- SDR order: LANES=1, RATIO=8, DDR=0, LSBFIRST=1, word 0xA5 -> out sequence 1,0,1,0,0,1,0,1 over 8 cycles; frame high only in cycle 1; busy high 8 cycles; then out=IDLE (0).
- DDR order: LANES=2, RATIO=4, DDR=1, in_data=0x6C -> lane0 (0xC) high/low phases (0,0),(1,1); lane1 (0x6) (0,1),(1,0); 2 cycles; in_ready high on the 2nd beat.
- Streaming: in_valid held with words 0x01, 0x02, 0x03 (RATIO=8, SDR) -> 24 contiguous bits, no idle cycle, frame pulses every 8 cycles, in_ready pulses on cycles 8, 16 and 24.
- Idle level and MSB-first: IDLE=1, LSBFIRST=0, word 0x80 -> out shows 1 then seven 0s, then returns to 1; out=1 before the first accept.
- Reset mid-word: assert reset at beat 3 of 0xFF -> next cycle out=IDLE, busy=0, frame=0, in_ready=0 while reset is high and 1 after release; no remaining bits emitted.
- Backpressure: in_valid with a new word in beat 2 of an active word -> word ignored (in_ready=0); the same word held until the last beat is accepted exactly once.
